clk_div_monitor: RTL and testbench
==================================

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameters SHALL be, one per line:
- CNT_W, 8, width of the ratio, period and high-time counters.
- SYNC_STAGES, 2, synchronizer depth on i_clk_divided (legal range 2..3).
- LOCK_CNT, 4, consecutive good periods required to lock.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- i_clk  input  1  single system clock; all logic on its rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_clk_divided  input  1  divided clock under test, sampled as data.
- i_en  input  1  monitor enable.
- i_ratio  input  CNT_W  expected division ratio (even, >=2).
- o_rise_pulse  output  1  one-cycle strobe per detected rising edge.
- o_fall_pulse  output  1  one-cycle strobe per detected falling edge.
- o_valid  output  1  one-cycle strobe; o_period/o_high_cnt updated.
- o_period  output  CNT_W  last measured period in i_clk cycles.
- o_high_cnt  output  CNT_W  last measured high time in i_clk cycles.
- o_locked  output  1  LOCK_CNT consecutive periods matched i_ratio.
- o_err  output  1  sticky error flag.
- o_err_code  output  2  0 none, 1 period mismatch, 2 duty mismatch, 3 timeout/invalid ratio.
REQ-003 Clock and reset SHALL be one clock i_clk with asynchronous active-low reset i_rstn; no other clock domain.

Function
REQ-004 i_clk_divided SHALL pass through SYNC_STAGES flops, then one edge-detect flop; edge strobes SHALL assert exactly SYNC_STAGES+1 cycles after the first i_clk edge that samples the new level.
REQ-005 FSM states SHALL be IDLE, WAIT_EDGE, MEASURE, LOCKED, ERROR.
REQ-006 IDLE->WAIT_EDGE when i_en=1 and i_ratio is even and >=2; with i_en=1 and an odd or <2 ratio, go to ERROR with code 3.
REQ-007 WAIT_EDGE->MEASURE on the first rise strobe; counters clear and no o_valid is produced for this edge.
REQ-008 In MEASURE/LOCKED the period counter SHALL count cycles between rise strobes, and the high counter SHALL count cycles from rise strobe to fall strobe; both saturate at 2^CNT_W-1.
REQ-009 On each subsequent rise strobe: latch o_period, latch o_high_cnt and pulse o_valid in the same cycle as o_rise_pulse; counters restart at 1.
REQ-010 A period is good iff period==i_ratio and high==i_ratio/2; the good-run counter increments on good, and MEASURE->LOCKED when it reaches LOCK_CNT.
REQ-011 A bad period SHALL set o_err with code 1 (period mismatch takes priority) or code 2, clear o_locked and go to ERROR.
REQ-012 No rise strobe within 2*i_ratio cycles in WAIT_EDGE/MEASURE/LOCKED SHALL go to ERROR with code 3.
REQ-013 ERROR SHALL hold o_err/o_err_code until i_en=0; then return to IDLE and clear the error.
REQ-014 i_en=0 in any state SHALL go to IDLE next cycle and clear o_locked and the counters; o_period/o_high_cnt keep their last values.
REQ-015 A change of i_ratio while not in IDLE SHALL be ignored; the ratio is captured on the IDLE->WAIT_EDGE transition.
REQ-016 Edge strobes SHALL run whenever out of reset, independent of i_en.

Reset
REQ-017 On i_rstn=0, all outputs, synchronizer flops, counters and the captured ratio SHALL be 0 and the FSM SHALL be IDLE.
REQ-018 Reset mid-measurement SHALL abort immediately; after release a full WAIT_EDGE is required before any o_valid.

Structure
REQ-019 A shared package SHALL hold the FSM state enum and the err-code constants (ERR_NONE, ERR_PERIOD, ERR_DUTY, ERR_TIMEOUT).
REQ-020 One sub-module, sync_edge_det (synchronizer plus rise/fall strobes), SHALL be instantiated; the FSM and counters stay in the top.

Verification
REQ-021 Ratio-4 divider (2 high/2 low), i_ratio=4, i_en=1 -> o_valid with period=4, high=2; o_locked after the 5th rise strobe.
REQ-022 Ratio-4 divider, i_ratio=6 -> first o_valid gives period=4, o_err=1, code=1, FSM ERROR.
REQ-023 Period 4 with 3-high/1-low, i_ratio=4 -> o_err=1, code=2.
REQ-024 i_clk_divided stuck at 0, i_ratio=4 -> o_err=1, code=3 after 8 cycles in WAIT_EDGE.
REQ-025 i_ratio=5 with i_en=1 -> ERROR with code 3 next cycle; i_en=0 -> IDLE and o_err=0.
REQ-026 Assert i_rstn=0 for 2 cycles while LOCKED -> all outputs 0; relock needs LOCK_CNT+1 rise strobes.

Source files
------------

// File: rtl/clk_div_monitor_pkg.sv
// Shared types for the divided-clock monitor: FSM state encoding and error codes.
package clk_div_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_EDGE = 3'd1,
        MEASURE   = 3'd2,
        LOCKED    = 3'd3,
        ERROR     = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PERIOD  = 2'd1;
    localparam logic [1:0] ERR_DUTY    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into i_clk and emits registered
// one-cycle rise/fall strobes from the synchronized level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            prev_q <= sync_q[SYNC_STAGES-1];
            o_rise <= sync_q[SYNC_STAGES-1] & ~prev_q;
            o_fall <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled as data, checks
// them against the expected ratio, and reports lock or a sticky error.
module clk_div_monitor
    import clk_div_monitor_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clk_divided,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_ratio,
    output logic             o_rise_pulse,
    output logic             o_fall_pulse,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic             o_locked,
    output logic             o_err,
    output logic [1:0]       o_err_code
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic              rise_s;
    logic              fall_s;
    logic [CNT_W-1:0]  ratio_q;
    logic [CNT_W-1:0]  period_cnt;
    logic [CNT_W-1:0]  high_cnt;
    logic              high_run;
    logic [CNT_W:0]    tmo_cnt;
    logic [GOOD_W-1:0] good_cnt;

    logic              ratio_ok;
    logic [CNT_W:0]    tmo_limit;
    logic              tmo_hit;
    logic              period_match;
    logic              duty_match;
    logic [CNT_W-1:0]  period_next;
    logic [CNT_W-1:0]  high_next;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_async (i_clk_divided),
        .o_rise  (rise_s),
        .o_fall  (fall_s)
    );

    // Timeout fires on the cycle that would make 2*ratio cycles without a rise.
    assign ratio_ok     = ~i_ratio[0] && (i_ratio >= CNT_W'(2));
    assign tmo_limit    = {ratio_q, 1'b0} - (CNT_W+1)'(1);
    assign tmo_hit      = (tmo_cnt == tmo_limit);
    assign period_match = (period_cnt == ratio_q);
    assign duty_match   = (high_cnt == (ratio_q >> 1));
    assign period_next  = (period_cnt == CNT_MAX) ? period_cnt : period_cnt + CNT_W'(1);
    assign high_next    = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= IDLE;
            ratio_q      <= '0;
            period_cnt   <= '0;
            high_cnt     <= '0;
            high_run     <= 1'b0;
            tmo_cnt      <= '0;
            good_cnt     <= '0;
            o_rise_pulse <= 1'b0;
            o_fall_pulse <= 1'b0;
            o_valid      <= 1'b0;
            o_period     <= '0;
            o_high_cnt   <= '0;
            o_locked     <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= ERR_NONE;
        end else begin
            o_rise_pulse <= rise_s;
            o_fall_pulse <= fall_s;
            o_valid      <= 1'b0;

            if (!i_en) begin
                state      <= IDLE;
                period_cnt <= '0;
                high_cnt   <= '0;
                high_run   <= 1'b0;
                tmo_cnt    <= '0;
                good_cnt   <= '0;
                o_locked   <= 1'b0;
                o_err      <= 1'b0;
                o_err_code <= ERR_NONE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ratio_ok) begin
                            ratio_q <= i_ratio;
                            tmo_cnt <= '0;
                            state   <= WAIT_EDGE;
                        end else begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_TIMEOUT;
                            state      <= ERROR;
                        end
                    end

                    // The first rise only aligns the counters; it carries no measurement.
                    WAIT_EDGE: begin
                        if (rise_s) begin
                            period_cnt <= CNT_W'(1);
                            high_cnt   <= CNT_W'(1);
                            high_run   <= 1'b1;
                            tmo_cnt    <= '0;
                            good_cnt   <= '0;
                            state      <= MEASURE;
                        end else if (tmo_hit) begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_TIMEOUT;
                            state      <= ERROR;
                        end else begin
                            tmo_cnt <= tmo_cnt + (CNT_W+1)'(1);
                        end
                    end

                    MEASURE, LOCKED: begin
                        if (rise_s) begin
                            o_valid    <= 1'b1;
                            o_period   <= period_cnt;
                            o_high_cnt <= high_cnt;
                            period_cnt <= CNT_W'(1);
                            high_cnt   <= CNT_W'(1);
                            high_run   <= 1'b1;
                            tmo_cnt    <= '0;
                            if (period_match && duty_match) begin
                                if (state == MEASURE) begin
                                    good_cnt <= good_cnt + GOOD_W'(1);
                                    if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                                        o_locked <= 1'b1;
                                        state    <= LOCKED;
                                    end
                                end
                            end else begin
                                o_err      <= 1'b1;
                                o_err_code <= period_match ? ERR_DUTY : ERR_PERIOD;
                                o_locked   <= 1'b0;
                                good_cnt   <= '0;
                                state      <= ERROR;
                            end
                        end else if (tmo_hit) begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_TIMEOUT;
                            o_locked   <= 1'b0;
                            good_cnt   <= '0;
                            state      <= ERROR;
                        end else begin
                            tmo_cnt    <= tmo_cnt + (CNT_W+1)'(1);
                            period_cnt <= period_next;
                            if (fall_s) begin
                                high_run <= 1'b0;
                            end else if (high_run) begin
                                high_cnt <= high_next;
                            end
                        end
                    end

                    ERROR: begin
                        state <= ERROR;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed self-checking bench for clk_div_monitor with a scoreboard of
// expected measurements consumed on every o_valid strobe.
module tb_clk_div_monitor;
    import clk_div_monitor_pkg::*;

    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_CNT    = 4;

    typedef struct packed {
        logic [7:0] period;
        logic [7:0] high;
        logic       locked;
        logic       err;
        logic [1:0] code;
    } exp_t;

    logic             i_clk = 1'b0;
    logic             i_rstn;
    logic             i_clk_divided;
    logic             i_en;
    logic [CNT_W-1:0] i_ratio;
    logic             o_rise_pulse;
    logic             o_fall_pulse;
    logic             o_valid;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high_cnt;
    logic             o_locked;
    logic             o_err;
    logic [1:0]       o_err_code;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   valid_seen = 0;
    int   rise_seen  = 0;
    int   div_hi     = 2;
    int   div_lo     = 2;
    int   div_phase  = 0;
    bit   div_run    = 1'b0;

    clk_div_monitor #(
        .CNT_W(CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .LOCK_CNT(LOCK_CNT)
    ) dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_clk_divided (i_clk_divided),
        .i_en          (i_en),
        .i_ratio       (i_ratio),
        .o_rise_pulse  (o_rise_pulse),
        .o_fall_pulse  (o_fall_pulse),
        .o_valid       (o_valid),
        .o_period      (o_period),
        .o_high_cnt    (o_high_cnt),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_err_code    (o_err_code)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp(input int period, input int high, input bit locked, input bit err, input int code);
        exp_t e;
        e.period = 8'(period);
        e.high   = 8'(high);
        e.locked = locked;
        e.err    = err;
        e.code   = 2'(code);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic start_div(input int hi, input int lo);
        div_hi    = hi;
        div_lo    = lo;
        div_phase = 0;
        div_run   = 1'b1;
    endtask

    task automatic stop_div();
        div_run       = 1'b0;
        i_clk_divided = 1'b0;
    endtask

    task automatic wait_valids(input int target, input int budget, input string tag);
        int k = 0;
        while (valid_seen < target && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        check_output(tag, 32'(valid_seen >= target), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_rise"},   32'(o_rise_pulse), 32'd0);
        check_output({tag, "_fall"},   32'(o_fall_pulse), 32'd0);
        check_output({tag, "_valid"},  32'(o_valid),      32'd0);
        check_output({tag, "_period"}, 32'(o_period),     32'd0);
        check_output({tag, "_high"},   32'(o_high_cnt),   32'd0);
        check_output({tag, "_locked"}, 32'(o_locked),     32'd0);
        check_output({tag, "_err"},    32'(o_err),        32'd0);
        check_output({tag, "_code"},   32'(o_err_code),   32'd0);
        check_output({tag, "_state"},  32'(dut.state),    32'(IDLE));
    endtask

    // Divided-clock generator: hi cycles high then lo cycles low, changed on negedges.
    initial begin
        forever begin
            @(negedge i_clk);
            if (div_run) begin
                i_clk_divided = (div_phase < div_hi);
                div_phase     = (div_phase + 1 >= div_hi + div_lo) ? 0 : div_phase + 1;
            end else begin
                div_phase = 0;
            end
        end
    end

    // Scoreboard consumer, sampled just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (o_rise_pulse) rise_seen++;
            if (o_valid) begin
                valid_seen++;
                check_output("sb_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_output("sb_period", 32'(o_period),   32'(e.period));
                    check_output("sb_high",   32'(o_high_cnt), 32'(e.high));
                    check_output("sb_locked", 32'(o_locked),   32'(e.locked));
                    check_output("sb_err",    32'(o_err),      32'(e.err));
                    check_output("sb_code",   32'(o_err_code), 32'(e.code));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int rise_base;
        int k;

        i_rstn        = 1'b0;
        i_en          = 1'b0;
        i_ratio       = '0;
        i_clk_divided = 1'b0;
        step(3);
        check_all_zero("reset");
        i_rstn = 1'b1;
        step(2);

        $display("[TB] edge strobe latency with monitor disabled");
        i_clk_divided = 1'b1;
        for (int i = 1; i <= SYNC_STAGES + 3; i++) begin
            @(negedge i_clk);
            check_output($sformatf("rise_lat_%0d", i), 32'(o_rise_pulse), 32'(i == SYNC_STAGES + 2));
            check_output($sformatf("rise_noval_%0d", i), 32'(o_valid), 32'd0);
        end
        i_clk_divided = 1'b0;
        for (int i = 1; i <= SYNC_STAGES + 3; i++) begin
            @(negedge i_clk);
            check_output($sformatf("fall_lat_%0d", i), 32'(o_fall_pulse), 32'(i == SYNC_STAGES + 2));
        end

        $display("[TB] ratio 4 divider locks; mid-run ratio change ignored");
        for (int i = 1; i <= 6; i++) push_exp(4, 2, i >= LOCK_CNT, 1'b0, 0);
        base    = valid_seen + 6;
        i_ratio = 8'd4;
        i_en    = 1'b1;
        start_div(2, 2);
        step(3);
        i_ratio = 8'd6;
        wait_valids(base, 200, "t1_valids");
        check_output("t1_locked", 32'(o_locked), 32'd1);
        check_output("t1_state",  32'(dut.state), 32'(LOCKED));
        i_en = 1'b0;
        stop_div();
        step(2);
        check_output("t1_dis_locked", 32'(o_locked),   32'd0);
        check_output("t1_dis_period", 32'(o_period),   32'd4);
        check_output("t1_dis_high",   32'(o_high_cnt), 32'd2);
        check_output("t1_dis_state",  32'(dut.state),  32'(IDLE));

        $display("[TB] ratio 4 divider against expected 6");
        push_exp(4, 2, 1'b0, 1'b1, 1);
        base    = valid_seen + 1;
        i_ratio = 8'd6;
        i_en    = 1'b1;
        start_div(2, 2);
        wait_valids(base, 200, "t2_valids");
        step(3);
        check_output("t2_err",   32'(o_err),      32'd1);
        check_output("t2_code",  32'(o_err_code), 32'(ERR_PERIOD));
        check_output("t2_state", 32'(dut.state),  32'(ERROR));
        i_en = 1'b0;
        stop_div();
        step(2);
        check_output("t2_clr_err",  32'(o_err),      32'd0);
        check_output("t2_clr_code", 32'(o_err_code), 32'd0);

        $display("[TB] period 4 with 3 high / 1 low");
        push_exp(4, 3, 1'b0, 1'b1, 2);
        base    = valid_seen + 1;
        i_ratio = 8'd4;
        i_en    = 1'b1;
        start_div(3, 1);
        wait_valids(base, 200, "t3_valids");
        step(2);
        check_output("t3_err",  32'(o_err),      32'd1);
        check_output("t3_code", 32'(o_err_code), 32'(ERR_DUTY));
        i_en = 1'b0;
        stop_div();
        step(2);

        $display("[TB] stuck divided clock times out");
        i_ratio = 8'd4;
        i_en    = 1'b1;
        step(8);
        check_output("t4_pre_err",   32'(o_err),     32'd0);
        check_output("t4_pre_state", 32'(dut.state), 32'(WAIT_EDGE));
        step(1);
        check_output("t4_err",   32'(o_err),      32'd1);
        check_output("t4_code",  32'(o_err_code), 32'(ERR_TIMEOUT));
        check_output("t4_state", 32'(dut.state),  32'(ERROR));
        i_en = 1'b0;
        step(2);

        $display("[TB] odd ratio rejected");
        i_ratio = 8'd5;
        i_en    = 1'b1;
        step(1);
        check_output("t5_err",   32'(o_err),      32'd1);
        check_output("t5_code",  32'(o_err_code), 32'(ERR_TIMEOUT));
        check_output("t5_state", 32'(dut.state),  32'(ERROR));
        i_en = 1'b0;
        step(1);
        check_output("t5_clr_err",   32'(o_err),     32'd0);
        check_output("t5_clr_state", 32'(dut.state), 32'(IDLE));

        $display("[TB] reset while locked, then relock");
        for (int i = 1; i <= 6; i++) push_exp(4, 2, i >= LOCK_CNT, 1'b0, 0);
        base    = valid_seen + 6;
        i_ratio = 8'd4;
        i_en    = 1'b1;
        start_div(2, 2);
        wait_valids(base, 200, "t6_valids");
        check_output("t6_locked", 32'(o_locked), 32'd1);
        i_rstn = 1'b0;
        stop_div();
        #1;
        check_all_zero("t6_reset");
        step(2);
        for (int i = 1; i <= 5; i++) push_exp(4, 2, i >= LOCK_CNT, 1'b0, 0);
        base      = valid_seen + 5;
        rise_base = rise_seen;
        i_rstn    = 1'b1;
        start_div(2, 2);
        k = 0;
        while (!o_locked && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check_output("t6_relock", 32'(o_locked), 32'd1);
        check_output("t6_relock_rises", 32'(rise_seen - rise_base), 32'(LOCK_CNT + 1));
        wait_valids(base, 200, "t6_relock_valids");
        i_en = 1'b0;
        stop_div();
        step(3);
        check_output("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
